// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronises the raw lines, assembles 11-bit frames, checks them
// and queues good scan codes in a FIFO drained by valid/ready. Optional macro: PS2_PARITY_CHECK_EN.
module ps2_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [2:0]    dat_sync_q, dat_sync_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          mem_we;

  logic          fall;
  logic          bit_in;
  logic          empty;
  logic          full;
  logic          pop;
  logic          parity_ok;
  logic          frame_ok;

  // Shift register holds start in bit 0, D0..D7 in bits 8:1, parity in bit 9.
  always_comb begin
    fall   = clk_sync_q[2] & ~clk_sync_q[1];
    bit_in = dat_sync_q[1];
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop    = !empty && ready;
`ifdef PS2_PARITY_CHECK_EN
    parity_ok = ^shift_q[9:1];
`else
    parity_ok = 1'b1;
`endif
    frame_ok = ~shift_q[0] & bit_in & parity_ok;
  end

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d  = {dat_sync_q[1:0], ps2_data};
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    idle_d      = idle_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    frame_err_d = 1'b0;
    mem_we      = 1'b0;

    if (fall) begin
      idle_d = '0;
      if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
        if (frame_ok) begin
          // A simultaneous pop frees the slot, so a full FIFO can still accept.
          if (!full || pop) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + (AW+1)'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        cnt_d   = cnt_q + 4'd1;
        shift_d = {bit_in, shift_q[9:1]};
      end
    end else if (cnt_q != 4'd0) begin
      if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
        cnt_d       = 4'd0;
        idle_d      = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end else begin
      idle_d = '0;
    end

    if (pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 3'b111;
      dat_sync_q  <= 3'b111;
      cnt_q       <= 4'd0;
      shift_q     <= 10'd0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      idle_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      idle_q      <= idle_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wptr_q[AW-1:0]] <= shift_q[8:1];
    end
  end

  assign valid     = !empty;
  assign data      = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
